conv1d_mac_engine: RTL and testbench

// - 1-D convolution MAC stage for the ECG CNN; sits between LSU read/write ports and the layer controller.
// - Fetches weights (LDM0, addr[7:6]=00) and samples (LDM1, addr[7:6]=01) through the shared LSU port-A address, one per cycle.
// - Accumulates Q-format products, then writes one saturated result per output through the LSU ALU write port.

---
 rtl/conv1d_mac_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_conv1d_mac_engine.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_mac_engine.sv
// 1-D convolution MAC stage: fetches weights/samples over the LSU port-A read path and writes saturated Q-format results.
// Optional build macro MAC_RELU_EN fuses a ReLU after saturation.
module conv1d_mac_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int ACC_WIDTH  = 40,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] cfg_w_base_in,
  input  logic [ADDR_WIDTH-1:0] cfg_x_base_in,
  input  logic [ADDR_WIDTH-1:0] cfg_y_base_in,
  input  logic [5:0]            cfg_taps_in,
  input  logic [5:0]            cfg_outs_in,
  input  logic [DATA_WIDTH-1:0] LSU_dout0_in,
  input  logic [DATA_WIDTH-1:0] LSU_dout1_in,
  output logic                  MAC_LDM_ena_out,
  output logic [ADDR_WIDTH-1:0] MAC_LDM_addra_out,
  output logic                  ALU_enb_out,
  output logic                  ALU_web_out,
  output logic [ADDR_WIDTH-1:0] ALU_addr_out,
  output logic [DATA_WIDTH-1:0] ALU_dout_out,
  output logic                  busy_out,
  output logic                  done_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_W = 3'd1,
    S_FETCH_X = 3'd2,
    S_FLUSH   = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                       state_q, state_d;
  logic [5:0]                   j_q, j_d, k_q, k_d;
  logic [5:0]                   taps_q, taps_d, outs_q, outs_d;
  logic [ADDR_WIDTH-1:0]        w_base_q, w_base_d, x_base_q, x_base_d, y_base_q, y_base_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]        w_q, w_d;

  logic                         ena_q, ena_d, enb_q, enb_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0]        addra_q, addra_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0]        dout_q, dout_d;

  logic signed [2*DATA_WIDTH-1:0] prod_full;
  logic signed [ACC_WIDTH-1:0]    prod_ext;

  assign prod_full = $signed(w_q) * $signed(LSU_dout1_in);
  assign prod_ext  = {{(ACC_WIDTH-2*DATA_WIDTH){prod_full[2*DATA_WIDTH-1]}}, prod_full};

  // Arithmetic shift back to the Q format, then clamp to the signed result range.
  function automatic logic [DATA_WIDTH-1:0] sat_fn(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0]       res;
    sh = acc >>> FRAC_BITS;
    if ((&sh[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|sh[ACC_WIDTH-1:DATA_WIDTH-1])) begin
      res = sh[DATA_WIDTH-1:0];
    end else if (sh[ACC_WIDTH-1]) begin
      res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`ifdef MAC_RELU_EN
    res = res[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : res;
`else
    res = res;
`endif
    return res;
  endfunction

  // Next-state, counter and accumulator update.
  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    w_d      = w_q;
    taps_d   = taps_q;
    outs_d   = outs_q;
    w_base_d = w_base_q;
    x_base_d = x_base_q;
    y_base_d = y_base_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          taps_d   = cfg_taps_in;
          outs_d   = cfg_outs_in;
          w_base_d = cfg_w_base_in;
          x_base_d = cfg_x_base_in;
          y_base_d = cfg_y_base_in;
          acc_d    = {ACC_WIDTH{1'b0}};
          j_d      = 6'd0;
          k_d      = 6'd0;
          if ((cfg_taps_in == 6'd0) || (cfg_outs_in == 6'd0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH_W;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH_W: begin
        // The sample read issued in the previous FETCH_X is on the bus now.
        if (k_q != 6'd0) begin
          acc_d = acc_q + prod_ext;
        end else begin
          acc_d = acc_q;
        end
        state_d = S_FETCH_X;
      end
      S_FETCH_X: begin
        w_d = LSU_dout0_in;
        if (k_q < (taps_q - 6'd1)) begin
          k_d     = k_q + 6'd1;
          state_d = S_FETCH_W;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        acc_d = {ACC_WIDTH{1'b0}};
        k_d   = 6'd0;
        if (j_q < (outs_q - 6'd1)) begin
          j_d     = j_q + 6'd1;
          state_d = S_FETCH_W;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the upcoming state, so every port comes straight from a flop.
  always_comb begin
    ena_d   = 1'b0;
    addra_d = {ADDR_WIDTH{1'b0}};
    enb_d   = 1'b0;
    addr_d  = {ADDR_WIDTH{1'b0}};
    dout_d  = {DATA_WIDTH{1'b0}};
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_FETCH_W: begin
        ena_d   = 1'b1;
        addra_d = w_base_d + ADDR_WIDTH'(k_d);
        busy_d  = 1'b1;
      end
      S_FETCH_X: begin
        ena_d   = 1'b1;
        addra_d = x_base_d + ADDR_WIDTH'(j_d) + ADDR_WIDTH'(k_d);
        busy_d  = 1'b1;
      end
      S_FLUSH: busy_d = 1'b1;
      S_WRITE: begin
        enb_d  = 1'b1;
        addr_d = y_base_d + ADDR_WIDTH'(j_d);
        dout_d = sat_fn(acc_d);
        busy_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      j_q      <= 6'd0;
      k_q      <= 6'd0;
      acc_q    <= {ACC_WIDTH{1'b0}};
      w_q      <= {DATA_WIDTH{1'b0}};
      taps_q   <= 6'd0;
      outs_q   <= 6'd0;
      w_base_q <= {ADDR_WIDTH{1'b0}};
      x_base_q <= {ADDR_WIDTH{1'b0}};
      y_base_q <= {ADDR_WIDTH{1'b0}};
      ena_q    <= 1'b0;
      addra_q  <= {ADDR_WIDTH{1'b0}};
      enb_q    <= 1'b0;
      addr_q   <= {ADDR_WIDTH{1'b0}};
      dout_q   <= {DATA_WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      w_q      <= w_d;
      taps_q   <= taps_d;
      outs_q   <= outs_d;
      w_base_q <= w_base_d;
      x_base_q <= x_base_d;
      y_base_q <= y_base_d;
      ena_q    <= ena_d;
      addra_q  <= addra_d;
      enb_q    <= enb_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign MAC_LDM_ena_out   = ena_q;
  assign MAC_LDM_addra_out = addra_q;
  assign ALU_enb_out       = enb_q;
  assign ALU_web_out       = enb_q;
  assign ALU_addr_out      = addr_q;
  assign ALU_dout_out      = dout_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;

endmodule

// File: tb/tb_conv1d_mac_engine.sv
// Directed bench for conv1d_mac_engine: LDM read model with 1-cycle latency, write/done monitor, per-scenario tasks.
module tb_conv1d_mac_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic [7:0]  cfg_w_base_in, cfg_x_base_in, cfg_y_base_in;
  logic [5:0]  cfg_taps_in, cfg_outs_in;
  logic [15:0] LSU_dout0_in, LSU_dout1_in;
  logic        MAC_LDM_ena_out;
  logic [7:0]  MAC_LDM_addra_out;
  logic        ALU_enb_out, ALU_web_out;
  logic [7:0]  ALU_addr_out;
  logic [15:0] ALU_dout_out;
  logic        busy_out, done_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];

  int          cyc = 0;
  int          wr_n = 0;
  int          ena_cnt = 0;
  int          web_bad = 0;
  int          done_cyc = -1;
  logic [7:0]  wr_addr [0:63];
  logic [15:0] wr_data [0:63];
  int          start_cyc;

  conv1d_mac_engine dut (
    .clk(clk), .rst(rst), .start_in(start_in),
    .cfg_w_base_in(cfg_w_base_in), .cfg_x_base_in(cfg_x_base_in), .cfg_y_base_in(cfg_y_base_in),
    .cfg_taps_in(cfg_taps_in), .cfg_outs_in(cfg_outs_in),
    .LSU_dout0_in(LSU_dout0_in), .LSU_dout1_in(LSU_dout1_in),
    .MAC_LDM_ena_out(MAC_LDM_ena_out), .MAC_LDM_addra_out(MAC_LDM_addra_out),
    .ALU_enb_out(ALU_enb_out), .ALU_web_out(ALU_web_out),
    .ALU_addr_out(ALU_addr_out), .ALU_dout_out(ALU_dout_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (MAC_LDM_ena_out) begin
      LSU_dout0_in <= mem0[MAC_LDM_addra_out];
      LSU_dout1_in <= mem1[MAC_LDM_addra_out];
    end
  end

  always @(negedge clk) begin
    if (MAC_LDM_ena_out) ena_cnt <= ena_cnt + 1;
    if (ALU_enb_out) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] <= ALU_addr_out;
        wr_data[wr_n] <= ALU_dout_out;
      end
      wr_n <= wr_n + 1;
      if (ALU_web_out !== 1'b1) web_bad <= web_bad + 1;
    end
    if (done_out) done_cyc <= cyc;
  end

  task automatic kick(input logic [7:0] wb, input logic [7:0] xb, input logic [7:0] yb,
                      input logic [5:0] t, input logic [5:0] n);
    @(negedge clk);
    cfg_w_base_in = wb; cfg_x_base_in = xb; cfg_y_base_in = yb;
    cfg_taps_in = t; cfg_outs_in = n;
    start_in = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_cyc > start_cyc) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done timeout: no done_out seen, required at start+%0d", name, exp_lat);
    end else if (done_cyc - start_cyc != exp_lat) begin
      errors++;
      $display("FAIL %s done time: got start+%0d, required start+%0d", name, done_cyc - start_cyc, exp_lat);
    end
    @(negedge clk);
  endtask

  task automatic check_write(input string name, input int idx, input logic [7:0] ea, input logic [15:0] ed);
    checks++;
    if (idx >= wr_n) begin
      errors++;
      $display("FAIL %s missing write #%0d: writes seen %0d, required addr %h data %h", name, idx, wr_n, ea, ed);
    end else if (wr_addr[idx] !== ea || wr_data[idx] !== ed) begin
      errors++;
      $display("FAIL %s write: got addr %h data %h, required addr %h data %h", name, wr_addr[idx], wr_data[idx], ea, ed);
    end
  endtask

  task automatic check_count(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({MAC_LDM_ena_out, MAC_LDM_addra_out, ALU_enb_out, ALU_web_out, ALU_addr_out,
         ALU_dout_out, busy_out, done_out} !== 45'd0) begin
      errors++;
      $display("FAIL %s outputs: ena %b addra %h enb %b web %b addr %h dout %h busy %b done %b, required all 0",
               name, MAC_LDM_ena_out, MAC_LDM_addra_out, ALU_enb_out, ALU_web_out, ALU_addr_out,
               ALU_dout_out, busy_out, done_out);
    end
  endtask

  task automatic load_basic();
    mem0[8'h00] = 16'h0100; mem0[8'h01] = 16'h0200; mem0[8'h02] = 16'hFF00;
    mem1[8'h40] = 16'h0100; mem1[8'h41] = 16'h0200; mem1[8'h42] = 16'h0300; mem1[8'h43] = 16'h0400;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_basic_conv();
    int base;
    load_basic();
    base = wr_n;
    kick(8'h00, 8'h40, 8'h80, 6'd3, 6'd2);
    checks++;
    if (busy_out !== 1'b1 || MAC_LDM_ena_out !== 1'b1 || MAC_LDM_addra_out !== 8'h00) begin
      errors++;
      $display("FAIL basic first fetch: busy %b ena %b addra %h, required 1 1 00",
               busy_out, MAC_LDM_ena_out, MAC_LDM_addra_out);
    end
    @(negedge clk);
    checks++;
    if (MAC_LDM_addra_out !== 8'h40) begin
      errors++;
      $display("FAIL basic sample addr: got %h, required 40", MAC_LDM_addra_out);
    end
    wait_done("basic", 17);
    check_write("basic y0", base, 8'h80, 16'h0200);
    check_write("basic y1", base + 1, 8'h81, 16'h0400);
    check_count("basic write count", wr_n - base, 2);
    check_count("web equals enb", web_bad, 0);
  endtask

  task automatic test_pos_sat();
    int base;
    mem0[8'h10] = 16'h7FFF; mem0[8'h11] = 16'h7FFF;
    mem1[8'h50] = 16'h7FFF; mem1[8'h51] = 16'h7FFF;
    base = wr_n;
    kick(8'h10, 8'h50, 8'h90, 6'd2, 6'd1);
    wait_done("pos_sat", 7);
    check_write("pos_sat", base, 8'h90, 16'h7FFF);
  endtask

  task automatic test_neg_sat();
    int base;
    logic [15:0] exp_v;
`ifdef MAC_RELU_EN
    exp_v = 16'h0000;
`else
    exp_v = 16'h8000;
`endif
    mem0[8'h20] = 16'h8000; mem0[8'h21] = 16'h8000;
    mem1[8'h60] = 16'h7FFF; mem1[8'h61] = 16'h7FFF;
    base = wr_n;
    kick(8'h20, 8'h60, 8'hA0, 6'd2, 6'd1);
    wait_done("neg_sat", 7);
    check_write("neg_sat", base, 8'hA0, exp_v);
  endtask

  task automatic test_zero_cfg();
    int base_w;
    int base_e;
    base_w = wr_n;
    base_e = ena_cnt;
    kick(8'h00, 8'h40, 8'hB0, 6'd0, 6'd5);
    wait_done("zero_taps", 1);
    kick(8'h00, 8'h40, 8'hB0, 6'd3, 6'd0);
    wait_done("zero_outs", 1);
    repeat (2) @(negedge clk);
    check_count("zero cfg reads", ena_cnt - base_e, 0);
    check_count("zero cfg writes", wr_n - base_w, 0);
  endtask

  task automatic test_busy_protect();
    int base;
    load_basic();
    base = wr_n;
    kick(8'h00, 8'h40, 8'hC0, 6'd3, 6'd2);
    @(negedge clk);
    start_in = 1'b1;
    cfg_taps_in = 6'd5;
    cfg_outs_in = 6'd1;
    cfg_y_base_in = 8'hD0;
    @(negedge clk);
    start_in = 1'b0;
    wait_done("busy", 17);
    check_write("busy y0", base, 8'hC0, 16'h0200);
    check_write("busy y1", base + 1, 8'hC1, 16'h0400);
    check_count("busy write count", wr_n - base, 2);
  endtask

  task automatic test_reset_midrun();
    int base;
    load_basic();
    base = wr_n;
    kick(8'h00, 8'h40, 8'hE0, 6'd3, 6'd2);
    for (int i = 0; i < 20 && cyc < start_cyc + 10; i++) @(negedge clk);
    checks++;
    if (MAC_LDM_addra_out !== 8'h41 || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL midrun position: addra %h busy %b, required 41 1", MAC_LDM_addra_out, busy_out);
    end
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrun reset");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_count("midrun writes", wr_n - base, 1);
    check_write("midrun y0", base, 8'hE0, 16'h0200);
    base = wr_n;
    kick(8'h00, 8'h40, 8'hE0, 6'd3, 6'd2);
    wait_done("after reset", 17);
    check_write("after reset y0", base, 8'hE0, 16'h0200);
    check_write("after reset y1", base + 1, 8'hE1, 16'h0400);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'h0000;
    end
    rst = 1'b1;
    start_in = 1'b0;
    cfg_w_base_in = 8'h00; cfg_x_base_in = 8'h00; cfg_y_base_in = 8'h00;
    cfg_taps_in = 6'd0; cfg_outs_in = 6'd0;
    LSU_dout0_in = 16'h0000;
    LSU_dout1_in = 16'h0000;
    test_reset();
    test_basic_conv();
    test_pos_sat();
    test_neg_sat();
    test_zero_cfg();
    test_busy_protect();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
